// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             V;

    modport master (
        output in_valid, A, B, B_in, out_ready,
        input  in_ready, out_valid, D, B_out, V
    );

    modport slave (
        input  in_valid, A, B, B_in, out_ready,
        output in_ready, out_valid, D, B_out, V
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - B_in, one DIGIT-bit slice per clock, LSB slice first.
// Valid/ready on both sides; one operation in flight at a time.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_subtractor_if.slave   bus
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CntW-1:0] LastK = CntW'(NDIG - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             carry_q, carry_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic [CntW-1:0]  k_q, k_d;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_sum;

    // Subtraction as A + ~B + carry, carry seeded with ~B_in.
    always_comb begin
        a_dig   = a_q[k_q*DIGIT +: DIGIT];
        b_dig   = b_q[k_q*DIGIT +: DIGIT];
        dig_sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, carry_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        d_d     = d_q;
        carry_d = carry_q;
        bout_d  = bout_q;
        v_d     = v_q;
        k_d     = k_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    carry_d = ~bus.B_in;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d[k_q*DIGIT +: DIGIT] = dig_sum[DIGIT-1:0];
                carry_d = dig_sum[DIGIT];
                if (k_q == LastK) begin
                    d_d     = work_d;
                    bout_d  = ~dig_sum[DIGIT];
                    v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (work_d[WIDTH-1] != a_q[WIDTH-1]);
                    k_d     = '0;
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            d_q     <= '0;
            carry_q <= 1'b0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.D         = d_q;
        bus.B_out     = bout_q;
        bus.V         = v_q;
    end

    // Held result must not move while the consumer stalls.
    a_done_stable: assert property (@(posedge clk) disable iff (rst)
        (state_q == StDone && !bus.out_ready) |=> (state_q == StDone && $stable(d_q)
                                                  && $stable(bout_q) && $stable(v_q)));

    a_hs_exclusive: assert property (@(posedge clk) !(bus.in_ready && bus.out_valid));

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle 16-bit subtractor that computes D = A − B − B_in four bits per clock. It pairs with the combinational 16-bit adder in the Summation block as the subtract path: area-cheap, nibble-serial, and wrapped in a valid/ready handshake on both sides so it can sit behind a register-file read port and ahead of a result writeback stage.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT
- DIGIT, 4, bits processed per RUN cycle; NDIG = WIDTH/DIGIT (4 by default)
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operands A, B, B_in are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend, sampled at the accept edge
- B  input  WIDTH  subtrahend, sampled at the accept edge
- B_in  input  1  borrow-in, sampled at the accept edge
- out_valid  output  1  D, B_out, V hold a new result (high only in DONE)
- out_ready  input  1  consumer takes result
- D  output  WIDTH  difference, A − B − B_in mod 2^WIDTH
- B_out  output  1  borrow-out; 1 iff A < B + B_in, unsigned
- V  output  1  signed overflow of the two's-complement subtraction

## Operation
- Single clock; reset is synchronous and active-high (clk, rst).
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); both decoded from registered state.
- IDLE: on in_valid && in_ready, capture A, B, B_in; carry ← ~B_in; digit counter k ← 0; go to RUN. in_valid low → stay.
- RUN, one digit per edge: {c, s} = A[k] + ~B[k] + carry over DIGIT-bit slices, with k = 0 (LSB slice) first. Write s into slice k of the working result, carry ← c, k ← k+1. After the edge that processes k = NDIG−1, load D ← working result, B_out ← ~c, V ← (A[MSB]≠B[MSB]) && (D[MSB]≠A[MSB]), and go to DONE.
- DONE: hold D, B_out, V and out_valid. On out_ready, go to IDLE. out_ready low → stay indefinitely (back-pressure); the outputs stay stable.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- D, B_out and V change only on DONE entry or reset. They keep the last result after the transfer.
- Counter wraps only by leaving RUN; the counter is log2(NDIG) bits wide.

## Timing
- Reset: the state is IDLE from the first edge with rst high. On that edge D=0, B_out=0, V=0, k=0, carry=0. While rst is high, in_ready=1 and out_valid=0, but in_valid is not accepted.
- rst has priority over every other event, including mid-RUN and in DONE. The in-flight operation is discarded and no out_valid is produced for it.
- Latency: accept at edge E0; digits processed at E1..E4; out_valid high in the cycle after E4. This is NDIG+1 edges from accept to result.
- Transfer at the first edge with out_valid && out_ready. in_ready rises in the following cycle; there is no same-cycle accept on the transfer edge.
- Minimum spacing between back-to-back operations is NDIG+2 = 6 cycles.

## Test plan
- A=1234h, B=2345h, B_in=0 → out_valid 5 edges after accept; D=EEEFh, B_out=1, V=0.
- A=0000h, B=0001h, B_in=0 → D=FFFFh, B_out=1, V=0. Then A=FFFFh, B=FFFFh, B_in=1 → D=FFFFh, B_out=1, V=0.
- A=8000h, B=0001h, B_in=0 → D=7FFFh, B_out=0, V=1. A=0FFFh, B=0001h, B_in=1 → D=0FFDh, B_out=0, V=0.
- Back-pressure: out_ready held low 3 cycles in DONE → out_valid stays 1, D/B_out/V stable, in_ready=0 and a new in_valid is ignored. Then out_ready=1 → IDLE, and in_ready=1 the next cycle.
- rst pulsed for one edge after the 2nd RUN edge → next cycle IDLE, in_ready=1, out_valid=0, D=0. The next operation, 0005h−0003h, gives D=0002h, B_out=0.
- Random sweep of 1000 operands with random in_valid/out_ready gaps → every result matches {~B_out, D} = A + ~B + ~B_in (17-bit). No lost or duplicated results.
